axi_lite_reg_master: RTL and testbench

- AXI4-Lite master that turns a simple command/response stream into single AXI-Lite read or write transactions.
- It is the initiator end of the register bus. It drives the axi_lite_regs slaves in the rate-limiter and generator pcores from on-chip control logic such as a config sequencer or a DMA-side register bridge.
- Exactly one transaction is outstanding at a time.

---
 rtl/axi_lite_pkg.sv | 30 +++
 rtl/axi_lite_reg_master.sv | 260 ++++++++++++++++++++++++++
 tb/tb_axi_lite_reg_master.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
//
// Shared definitions for the AXI4-Lite register bus blocks.
//   - resp_t and the four AXI response codes (OKAY, EXOKAY, SLVERR, DECERR)
//   - state_t and the register master FSM encodings
//     (IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN)
//
// The states are plain localparam constants rather than an enum so that
// older tools and mixed-language wrappers can use the same values.
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    typedef logic [1:0] resp_t;
    typedef logic [2:0] state_t;

    localparam resp_t OKAY   = 2'b00;
    localparam resp_t EXOKAY = 2'b01;
    localparam resp_t SLVERR = 2'b10;
    localparam resp_t DECERR = 2'b11;

    localparam state_t IDLE    = 3'd0;
    localparam state_t WR_REQ  = 3'd1;
    localparam state_t WR_RESP = 3'd2;
    localparam state_t RD_REQ  = 3'd3;
    localparam state_t RD_RESP = 3'd4;
    localparam state_t RSP     = 3'd5;
    localparam state_t DRAIN   = 3'd6;

endpackage

// File: rtl/axi_lite_reg_master.sv
// ---------------------------------------------------------------------------
// axi_lite_reg_master
//
// AXI4-Lite master that turns a simple command/response stream into single
// AXI-Lite read or write transactions, one outstanding at a time.
//
// Ports
//   m_axi_aclk, m_axi_areset      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_rnw, cmd_addr,            1=read / 0=write, byte address,
//   cmd_wdata, cmd_wstrb          write data and strobes
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_resp,          read data (0 for writes), AXI response,
//   rsp_timeout                   response was synthesised by the timeout
//   m_axi_*                       AXI4-Lite master channels AW, W, B, AR, R
//
// Optional feature
//   AXI_LITE_REG_MASTER_TIMEOUT_EN: when defined, a response that does not
//   arrive within C_TIMEOUT_CYCLES is answered locally with SLVERR and
//   rsp_timeout=1; the late response is then absorbed in DRAIN. When not
//   defined the block waits for the slave indefinitely.
// ---------------------------------------------------------------------------
module axi_lite_reg_master
    import axi_lite_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                            m_axi_aclk,
    input  logic                            m_axi_areset,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_rnw,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                      m_axi_arprot,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
);

    // The timeout limit is meaningless below 2, so refuse to elaborate.
    if (C_TIMEOUT_CYCLES < 2) begin : g_badTimeout
        $error("C_TIMEOUT_CYCLES must be at least 2");
    end

    state_t                          r_state;
    logic                            r_rnw;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] r_wstrb;
    logic                            r_awvalid;
    logic                            r_wvalid;
    logic                            r_arvalid;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_rspData;
    resp_t                           r_rspResp;

    // A write channel counts as done once its handshake happened earlier
    // (valid already dropped) or is happening in this cycle.
    logic w_awDone;
    logic w_wDone;

    assign w_awDone = !r_awvalid || m_axi_awready;
    assign w_wDone  = !r_wvalid  || m_axi_wready;

`ifdef AXI_LITE_REG_MASTER_TIMEOUT_EN
    localparam int CntW = $clog2(C_TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(C_TIMEOUT_CYCLES - 1);

    logic            r_timeout;
    logic [CntW-1:0] r_count;
`endif

    // Main FSM and datapath. The command is latched on acceptance so the AXI
    // channels are driven from stable copies for the whole transaction. In
    // the response states the real response is checked before the timeout,
    // so a response arriving on the limit cycle always wins.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            r_state   <= IDLE;
            r_rnw     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rspData <= '0;
            r_rspResp <= OKAY;
`ifdef AXI_LITE_REG_MASTER_TIMEOUT_EN
            r_timeout <= 1'b0;
            r_count   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_rnw   <= cmd_rnw;
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_wdata;
                        r_wstrb <= cmd_wstrb;
                        if (cmd_rnw) begin
                            r_arvalid <= 1'b1;
                            r_state   <= RD_REQ;
                        end else begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    if (m_axi_awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (m_axi_wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_awDone && w_wDone) begin
                        r_state <= WR_RESP;
`ifdef AXI_LITE_REG_MASTER_TIMEOUT_EN
                        r_count <= '0;
`endif
                    end
                end

                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        r_rspResp <= m_axi_bresp;
                        r_rspData <= '0;
`ifdef AXI_LITE_REG_MASTER_TIMEOUT_EN
                        r_timeout <= 1'b0;
`endif
                        r_state   <= RSP;
                    end
`ifdef AXI_LITE_REG_MASTER_TIMEOUT_EN
                    else if (r_count == CntLast) begin
                        r_rspResp <= SLVERR;
                        r_rspData <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= RSP;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
`endif
                end

                RD_REQ: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= RD_RESP;
`ifdef AXI_LITE_REG_MASTER_TIMEOUT_EN
                        r_count   <= '0;
`endif
                    end
                end

                RD_RESP: begin
                    if (m_axi_rvalid) begin
                        r_rspResp <= m_axi_rresp;
                        r_rspData <= m_axi_rdata;
`ifdef AXI_LITE_REG_MASTER_TIMEOUT_EN
                        r_timeout <= 1'b0;
`endif
                        r_state   <= RSP;
                    end
`ifdef AXI_LITE_REG_MASTER_TIMEOUT_EN
                    else if (r_count == CntLast) begin
                        r_rspResp <= SLVERR;
                        r_rspData <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= RSP;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
`endif
                end

                RSP: begin
                    if (rsp_ready) begin
`ifdef AXI_LITE_REG_MASTER_TIMEOUT_EN
                        // A timed-out transaction still owes us a response
                        // from the slave; swallow it before taking new work.
                        r_state <= r_timeout ? DRAIN : IDLE;
`else
                        r_state <= IDLE;
`endif
                    end
                end

`ifdef AXI_LITE_REG_MASTER_TIMEOUT_EN
                DRAIN: begin
                    if ((r_rnw && m_axi_rvalid) || (!r_rnw && m_axi_bvalid)) begin
                        r_state <= IDLE;
                    end
                end
`endif

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // cmd_ready is gated by reset so it stays low for the whole reset
    // window, including the first cycle before the state register clears.
    assign cmd_ready = (r_state == IDLE) && !m_axi_areset;

    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;

`ifdef AXI_LITE_REG_MASTER_TIMEOUT_EN
    assign m_axi_bready = (r_state == WR_RESP) || ((r_state == DRAIN) && !r_rnw);
    assign m_axi_rready = (r_state == RD_RESP) || ((r_state == DRAIN) && r_rnw);
    assign rsp_timeout  = r_timeout;
`else
    assign m_axi_bready = (r_state == WR_RESP);
    assign m_axi_rready = (r_state == RD_RESP);
    assign rsp_timeout  = 1'b0;
`endif

    assign rsp_valid = (r_state == RSP);
    assign rsp_rdata = r_rspData;
    assign rsp_resp  = r_rspResp;

endmodule

// File: tb/tb_axi_lite_reg_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_reg_master
//
// Directed bench for axi_lite_reg_master. The AXI slave side is driven cycle
// by cycle from the main initial block, and every expected value is written
// out by hand. With AXI_LITE_REG_MASTER_TIMEOUT_EN defined the timeout and
// DRAIN path is exercised as well (C_TIMEOUT_CYCLES=8).
// ---------------------------------------------------------------------------
module tb_axi_lite_reg_master;

    logic        clk = 1'b0;
    logic        areset = 1'b1;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rnw = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;

    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;

    int numChecks = 0;
    int numFails  = 0;

    axi_lite_reg_master #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (32),
        .C_TIMEOUT_CYCLES   (8)
    ) dut (
        .m_axi_aclk    (clk),
        .m_axi_areset  (areset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rnw       (cmd_rnw),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command in IDLE for a single cycle; returns in cycle 1.
    task automatic applyStimulus(input logic rnw, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb);
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        #1;
        checkOutput("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFFF;
        cmd_wdata = 32'hFFFF_FFFF;
        checkOutput("cmd_ready_busy", cmd_ready, 0);
    endtask

    // Complete the response handshake and confirm return to IDLE.
    task automatic finishRsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_done", rsp_valid, 0);
        checkOutput("cmd_ready_done", cmd_ready, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_awvalid", awvalid, 0);
        checkOutput("rst_wvalid", wvalid, 0);
        checkOutput("rst_arvalid", arvalid, 0);
        checkOutput("rst_bready", bready, 0);
        checkOutput("rst_rready", rready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 0);
        checkOutput("rst_rsp_resp", rsp_resp, 0);
        checkOutput("rst_rsp_timeout", rsp_timeout, 0);
        areset = 1'b0;

        // Read 0x14, arready delayed so arvalid is held 5 cycles
        applyStimulus(1'b1, 32'h14, 32'h0, 4'h0);
        for (int i = 1; i <= 5; i++) begin
            checkOutput("rd_arvalid_held", arvalid, 1);
            checkOutput("rd_araddr", araddr, 32'h14);
            checkOutput("rd_arprot", arprot, 0);
            checkOutput("rd_rready_early", rready, 0);
            if (i == 5) arready = 1'b1;
            tick();
        end
        arready = 1'b0;
        checkOutput("rd_arvalid_drop", arvalid, 0);
        checkOutput("rd_rready", rready, 1);
        checkOutput("rd_rsp_early", rsp_valid, 0);
        rvalid = 1'b1;
        rdata  = 32'h1234_5678;
        rresp  = 2'b00;
        tick();
        rvalid = 1'b0;
        rdata  = 32'h0;
        checkOutput("rd_rsp_valid", rsp_valid, 1);
        checkOutput("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
        checkOutput("rd_rsp_resp", rsp_resp, 0);
        checkOutput("rd_rready_off", rready, 0);
        finishRsp();

        // Write 0x10 with an always-ready slave: rsp_valid at cycle 3
        applyStimulus(1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF);
        awready = 1'b1;
        wready  = 1'b1;
        checkOutput("wr_awvalid", awvalid, 1);
        checkOutput("wr_wvalid", wvalid, 1);
        checkOutput("wr_awaddr", awaddr, 32'h10);
        checkOutput("wr_awprot", awprot, 0);
        checkOutput("wr_wdata", wdata, 32'hDEAD_BEEF);
        checkOutput("wr_wstrb", wstrb, 4'hF);
        checkOutput("wr_bready_early", bready, 0);
        tick();
        awready = 1'b0;
        wready  = 1'b0;
        checkOutput("wr_awvalid_drop", awvalid, 0);
        checkOutput("wr_wvalid_drop", wvalid, 0);
        checkOutput("wr_bready", bready, 1);
        checkOutput("wr_rsp_early", rsp_valid, 0);
        bvalid = 1'b1;
        bresp  = 2'b00;
        tick();
        bvalid = 1'b0;
        checkOutput("wr_rsp_valid_c3", rsp_valid, 1);
        checkOutput("wr_rsp_resp", rsp_resp, 0);
        checkOutput("wr_rsp_rdata", rsp_rdata, 0);
        checkOutput("wr_rsp_timeout", rsp_timeout, 0);
        finishRsp();

        // Write with awready at cycle 1 and wready delayed to cycle 4
        applyStimulus(1'b0, 32'h20, 32'h0BAD_F00D, 4'h3);
        awready = 1'b1;
        checkOutput("st_awvalid_c1", awvalid, 1);
        checkOutput("st_wvalid_c1", wvalid, 1);
        tick();
        awready = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            checkOutput("st_awvalid_low", awvalid, 0);
            checkOutput("st_wvalid_held", wvalid, 1);
            checkOutput("st_wdata", wdata, 32'h0BAD_F00D);
            checkOutput("st_wstrb", wstrb, 4'h3);
            checkOutput("st_bready_early", bready, 0);
            if (c == 4) wready = 1'b1;
            tick();
        end
        wready = 1'b0;
        checkOutput("st_wvalid_drop", wvalid, 0);
        checkOutput("st_bready", bready, 1);
        bvalid = 1'b1;
        bresp  = 2'b00;
        tick();
        bvalid = 1'b0;
        checkOutput("st_rsp_valid", rsp_valid, 1);
        checkOutput("st_rsp_resp", rsp_resp, 0);
        finishRsp();

        // Read answered with DECERR, rsp_ready held low for 3 cycles
        applyStimulus(1'b1, 32'h18, 32'h0, 4'h0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        checkOutput("de_rready", rready, 1);
        rvalid = 1'b1;
        rresp  = 2'b11;
        rdata  = 32'hA5A5_5A5A;
        tick();
        rvalid = 1'b0;
        rresp  = 2'b00;
        for (int k = 0; k < 3; k++) begin
            checkOutput("de_rsp_valid", rsp_valid, 1);
            checkOutput("de_rsp_resp", rsp_resp, 2'b11);
            checkOutput("de_cmd_ready", cmd_ready, 0);
            tick();
        end
        checkOutput("de_rsp_valid_4", rsp_valid, 1);
        checkOutput("de_rsp_resp_4", rsp_resp, 2'b11);
        checkOutput("de_rsp_rdata", rsp_rdata, 32'hA5A5_5A5A);
        finishRsp();

        // Reset pulsed in WR_RESP, then a normal read
        applyStimulus(1'b0, 32'h24, 32'h0000_0011, 4'hF);
        awready = 1'b1;
        wready  = 1'b1;
        tick();
        awready = 1'b0;
        wready  = 1'b0;
        checkOutput("rs_bready", bready, 1);
        areset = 1'b1;
        tick();
        checkOutput("rs_awvalid", awvalid, 0);
        checkOutput("rs_wvalid", wvalid, 0);
        checkOutput("rs_arvalid", arvalid, 0);
        checkOutput("rs_bready_off", bready, 0);
        checkOutput("rs_rready", rready, 0);
        checkOutput("rs_rsp_valid", rsp_valid, 0);
        checkOutput("rs_cmd_ready", cmd_ready, 0);
        areset = 1'b0;
        applyStimulus(1'b1, 32'h28, 32'h0, 4'h0);
        arready = 1'b1;
        checkOutput("rs_rd_arvalid", arvalid, 1);
        checkOutput("rs_rd_araddr", araddr, 32'h28);
        tick();
        arready = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'hCAFE_F00D;
        rresp  = 2'b00;
        tick();
        rvalid = 1'b0;
        rdata  = 32'h0;
        checkOutput("rs_rd_rsp_valid", rsp_valid, 1);
        checkOutput("rs_rd_rdata", rsp_rdata, 32'hCAFE_F00D);
        checkOutput("rs_rd_resp", rsp_resp, 0);
        finishRsp();

`ifdef AXI_LITE_REG_MASTER_TIMEOUT_EN
        // Write with no bvalid: timeout after 8 cycles, late bvalid at 20
        applyStimulus(1'b0, 32'h30, 32'h5555_AAAA, 4'hF);
        awready = 1'b1;
        wready  = 1'b1;
        tick();
        awready = 1'b0;
        wready  = 1'b0;
        for (int c = 2; c <= 9; c++) begin
            checkOutput("to_bready_wait", bready, 1);
            checkOutput("to_rsp_wait", rsp_valid, 0);
            tick();
        end
        checkOutput("to_rsp_valid", rsp_valid, 1);
        checkOutput("to_rsp_resp", rsp_resp, 2'b10);
        checkOutput("to_rsp_timeout", rsp_timeout, 1);
        checkOutput("to_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        for (int c = 11; c <= 19; c++) begin
            checkOutput("to_drain_cmd_ready", cmd_ready, 0);
            checkOutput("to_drain_bready", bready, 1);
            checkOutput("to_drain_rsp_valid", rsp_valid, 0);
            tick();
        end
        bvalid = 1'b1;
        bresp  = 2'b00;
        tick();
        bvalid = 1'b0;
        checkOutput("to_after_cmd_ready", cmd_ready, 1);
        checkOutput("to_after_bready", bready, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
